// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the serial pattern generator and its detector bench.
// Contents: FSM state enum, default pattern constant.
// No logic; imported by seq_gen and by benches.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default pattern for the 4-bit configuration (use_def=1).
  localparam logic [3:0] DEF_PAT_DFLT = 4'b1101;

endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: request/config inputs and serial outputs of the pattern generator.
// Ports: start/use_def/pat_in/rep_cnt/gap_len (requester -> generator),
//        x/x_valid/busy/done (generator -> requester).
interface seq_gen_if #(
  parameter int W = 4
);
  logic         start;
  logic         use_def;
  logic [W-1:0] pat_in;
  logic [3:0]   rep_cnt;
  logic [1:0]   gap_len;
  logic         x;
  logic         x_valid;
  logic         busy;
  logic         done;

  // Requester side (bench or upstream control).
  modport master (
    output start, use_def, pat_in, rep_cnt, gap_len,
    input  x, x_valid, busy, done
  );

  // Generator side.
  modport slave (
    input  start, use_def, pat_in, rep_cnt, gap_len,
    output x, x_valid, busy, done
  );
endinterface

// File: rtl/seq_bit_ctr.sv
// seq_bit_ctr: loadable down-counter shared for bit and gap timing; saturates at zero.
// Latency: load/decrement take effect on the next rising edge; zero is registered-state decode.
// Ports: clk, reset (sync, active-high), load, load_val, dec, zero.
module seq_bit_ctr #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrement at zero holds so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator; sends rep_cnt copies of a W-bit pattern MSB first,
//          with gap_len idle bit-times between copies, then a one-cycle done pulse.
// Latency: first bit one cycle after start is accepted; start ignored while busy.
// Ports: clk, reset (sync, active-high), bus (seq_gen_if.slave).
module seq_gen
  import seq_pkg::*;
#(
  parameter int           W       = 4,
  parameter logic [W-1:0] DEF_PAT = W'(DEF_PAT_DFLT)
) (
  input  logic      clk,
  input  logic      reset,
  seq_gen_if.slave  bus
);

  localparam int            CW       = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;   // bit on its way out sits in [W-1]
  logic [W-1:0]  pat_q, pat_d;       // copy reloaded at the start of each repetition
  logic [3:0]    reps_q, reps_d;     // copies left, including the one being sent
  logic [1:0]    gap_q, gap_d;
  logic          x_q, x_d;
  logic          x_valid_q, x_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          ctr_load;
  logic [CW-1:0] ctr_val;
  logic          ctr_dec;
  logic          ctr_zero;

  // One counter serves both phases: bits left in a copy during SHIFT,
  // idle cycles left during GAP. Zero means "this is the last cycle of the phase".
  seq_bit_ctr #(.CW(CW)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      reps_q    <= reps_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    pat_d    = pat_q;
    reps_d   = reps_q;
    gap_d    = gap_q;
    ctr_load = 1'b0;
    ctr_val  = LAST_BIT;
    ctr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.rep_cnt != 4'd0)) begin
          state_d  = SHIFT;
          pat_d    = bus.use_def ? DEF_PAT : bus.pat_in;
          shreg_d  = pat_d;
          reps_d   = bus.rep_cnt;
          gap_d    = bus.gap_len;
          ctr_load = 1'b1;
        end
      end
      SHIFT: begin
        if (!ctr_zero) begin
          ctr_dec = 1'b1;
          shreg_d = shreg_q << 1;
        end else begin
          // LSB is on the line this cycle; reps_q >= 1 here, so no wrap.
          reps_d = reps_q - 4'd1;
          if (reps_q == 4'd1) begin
            state_d = DONE;
          end else if (gap_q != 2'd0) begin
            state_d  = GAP;
            ctr_load = 1'b1;
            ctr_val  = CW'(gap_q - 2'd1);
          end else begin
            shreg_d  = pat_q;
            ctr_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (ctr_zero) begin
          state_d  = SHIFT;
          shreg_d  = pat_q;
          ctr_load = 1'b1;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with state_q.
  always_comb begin
    x_valid_d = (state_d == SHIFT);
    x_d       = x_valid_d & shreg_d[W-1];
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
